tape_out_decoder: RTL

- Decodes the Oric cassette output waveform (K7_TAPEOUT) back into a byte stream, so the core can save tapes written by CSAVE.
- It is the receive-side counterpart of the tape player path:
  - the player feeds tape_in to the ROM loader;
  - this block listens to the ROM saver.
- Bytes leave through a valid/ready port into the upload FIFO that sits in front of ioctl.
- Runs entirely in the clk_sys domain.

---
 rtl/tape_out_decoder_if.sv | 22 ++
 rtl/tape_out_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tape_out_decoder_if.sv
// Byte stream port of the tape output decoder: decoded byte, parity flag and
// a valid/ready handshake toward the upload FIFO.
interface tape_out_decoder_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       parity_err;

  modport master (
    output byte_data,
    output byte_valid,
    output parity_err,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    input  parity_err,
    output byte_ready
  );
endinterface

// File: rtl/tape_out_decoder.sv
// Recovers bytes from the Oric cassette output waveform by measuring
// rise-to-rise periods and walking the leader/start/data/parity/stop frame.
module tape_out_decoder #(
  parameter int unsigned MIN_PERIOD = 2000,
  parameter int unsigned SHORT_MAX  = 7488,
  parameter int unsigned TIMEOUT    = 480000,
  parameter int unsigned SYNC_ONES  = 16
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      tape_out,
  tape_out_decoder_if.master        byte_if,
  output logic                      framing_err,
  output logic                      overflow,
  input  logic                      clear,
  output logic                      active,
  output logic [15:0]               byte_count
);

  localparam int CNT_W = 20;
  localparam int RUN_W = $clog2(SYNC_ONES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic             tape_p0, tape_p1, tape_p2, rise_p3;
  logic [CNT_W-1:0] period_cnt;
  logic             armed;
  logic             valid_rise, bit_ev, bit_val, timeout;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             load_d, perr_d, ferr_d;

  logic [7:0]       hold_data;
  logic             hold_valid, hold_perr;
  logic             accept;

  // Stage p0..p3: two-flop synchroniser, edge register, registered rise flag
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tape_p0 <= 1'b0;
      tape_p1 <= 1'b0;
      tape_p2 <= 1'b0;
      rise_p3 <= 1'b0;
    end else begin
      tape_p0 <= tape_out;
      tape_p1 <= tape_p0;
      tape_p2 <= tape_p1;
      rise_p3 <= tape_p1 & ~tape_p2;
    end
  end

  // Period measurement and bit classification
  assign valid_rise = rise_p3 && (period_cnt >= CNT_W'(MIN_PERIOD));
  assign bit_ev     = valid_rise && armed;
  assign bit_val    = (period_cnt <= CNT_W'(SHORT_MAX));
  assign timeout    = !valid_rise && (period_cnt >= CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
    end else if (valid_rise) begin
      period_cnt <= '0;
    end else if (period_cnt >= CNT_W'(TIMEOUT - 1)) begin
      period_cnt <= CNT_W'(TIMEOUT);
    end else begin
      period_cnt <= period_cnt + CNT_W'(1);
    end
  end

  // Any return to IDLE disarms, so the next edge only restarts the period.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b0;
    end else if (!enable || timeout || ferr_d) begin
      armed <= 1'b0;
    end else if (valid_rise && !armed) begin
      armed <= 1'b1;
    end
  end

  // Frame state machine
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    sh_q <= sh_d;
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    load_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (!enable || timeout) begin
      state_d = ST_IDLE;
      run_d   = '0;
    end else if (bit_ev) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!bit_val) begin
            run_d = '0;
          end else if (run_q >= RUN_W'(SYNC_ONES - 1)) begin
            run_d   = '0;
            state_d = ST_HUNT;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        ST_HUNT: begin
          if (!bit_val) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
        ST_DATA: begin
          sh_d  = {bit_val, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          load_d  = 1'b1;
          perr_d  = (bit_val != ~^sh_q);
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (bit_val) begin
            state_d = ST_HUNT;
          end else begin
            ferr_d  = 1'b1;
            run_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign active = (state_q != ST_IDLE);

  // Output holding register and handshake
  assign accept = hold_valid && byte_if.byte_ready;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_data   <= '0;
      hold_perr   <= 1'b0;
      hold_valid  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
      byte_count  <= '0;
    end else begin
      framing_err <= ferr_d;
      if (load_d && (!hold_valid || accept)) begin
        hold_data  <= sh_q;
        hold_perr  <= perr_d;
        hold_valid <= 1'b1;
      end else if (accept) begin
        hold_valid <= 1'b0;
      end
      if (clear) begin
        overflow <= 1'b0;
      end else if (load_d && hold_valid && !accept) begin
        overflow <= 1'b1;
      end
      if (clear) begin
        byte_count <= '0;
      end else if (accept) begin
        byte_count <= byte_count + 16'd1;
      end
    end
  end

  assign byte_if.byte_data  = hold_data;
  assign byte_if.byte_valid = hold_valid;
  assign byte_if.parity_err = hold_perr;

endmodule
